// File: rtl/data_sram_like_slave_if.sv
// SRAM-like data port bundle between a requester (master) and a memory responder (slave).
interface data_sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_like_slave.sv
// Data-memory responder for the SRAM-like port: one outstanding request, byte-lane writes
// committed at acceptance, completion pulse a fixed LATENCY cycles later.
module data_sram_like_slave #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    data_sram_like_slave_if.slave   bus
);
    localparam int         DEPTH = 2 ** AW;
    localparam logic [3:0] LOAD  = 4'(LATENCY);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        stateReg, stateNext;
    logic [3:0]    cntReg, cntNext;
    logic          dataOkReg, dataOkNext;
    logic          errPendReg;
    logic [31:0]   pendReg;
    logic [31:0]   holdReg;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [3:0]    byteEn;
    logic          sizeErr;
    logic          addrOk;
    logic          accept;

    // Upper address bits alias onto the array, so they are deliberately not decoded.
    wire unusedAddrBits = ^bus.addr[31:AW+2];

    assign idx    = bus.addr[AW+1:2];
    assign addrOk = (stateReg == IDLE) | dataOkReg;
    assign accept = bus.req & addrOk;

    // Decode size/offset into byte-lane enables, flagging misaligned or reserved sizes.
    always_comb begin
        byteEn  = 4'b0000;
        sizeErr = 1'b0;
        case (bus.size)
            2'd0: byteEn = 4'b0001 << bus.addr[1:0];
            2'd1: begin
                if (!bus.addr[0]) byteEn = 4'b0011 << bus.addr[1:0];
                else              sizeErr = 1'b1;
            end
            2'd2: begin
                if (bus.addr[1:0] == 2'b00) byteEn = 4'b1111;
                else                        sizeErr = 1'b1;
            end
            default: sizeErr = 1'b1;
        endcase
    end

    // Next-state logic: count down while busy, reload on any acceptance (including back-to-back).
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        if (stateReg == BUSY && cntReg != 4'd0) cntNext = cntReg - 4'd1;
        if (stateReg == BUSY && dataOkReg)      stateNext = IDLE;
        if (accept) begin
            stateNext = BUSY;
            cntNext   = LOAD;
        end
        dataOkNext = (stateNext == BUSY) && (cntNext == 4'd1);
    end

    // Control registers; a reset discards any in-flight completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            cntReg     <= 4'd0;
            dataOkReg  <= 1'b0;
            errPendReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            cntReg    <= cntNext;
            dataOkReg <= dataOkNext;
            if (accept) errPendReg <= sizeErr;
        end
    end

    // Array access at acceptance: read-first into the pending register, then lane-masked write.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            pendReg <= mem[idx];
            if (bus.wr && !sizeErr) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteEn[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // Keep the last delivered word so rdata is stable between completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            holdReg <= 32'd0;
        else if (dataOkReg) holdReg <= pendReg;
    end

    assign bus.addr_ok = addrOk;
    assign bus.data_ok = dataOkReg;
    assign bus.err     = dataOkReg & errPendReg;
    assign bus.rdata   = dataOkReg ? pendReg : holdReg;
endmodule

// File: tb/tb_data_sram_like_slave.sv
// Bench for data_sram_like_slave: four instances (LATENCY 1..4) share one stimulus driver;
// a transaction-level model predicts every completion cycle, rdata and err.
module tb_data_sram_like_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqV = 1'b0;
    logic        wrV = 1'b0;
    logic [1:0]  sizeV = 2'd0;
    logic [31:0] addrV = 32'd0;
    logic [31:0] wdataV = 32'd0;
    int          sel = 0;

    logic [3:0]  aokA, dOkA, errA;
    logic [31:0] rdA [4];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        data_sram_like_slave_if bus();
        assign bus.req   = reqV && (sel == gi);
        assign bus.wr    = wrV;
        assign bus.size  = sizeV;
        assign bus.addr  = addrV;
        assign bus.wdata = wdataV;
        assign aokA[gi]  = bus.addr_ok;
        assign dOkA[gi]  = bus.data_ok;
        assign errA[gi]  = bus.err;
        assign rdA[gi]   = bus.rdata;
        data_sram_like_slave #(.AW(10), .LATENCY(gi + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        int          due;
        logic [31:0] rdata;
        bit          known;
        bit          err;
    } pend_t;

    pend_t       q[$];
    logic [31:0] mdl   [4][1024];
    bit          known [4][1024];
    logic [31:0] lastR [4];
    bit          lastKnown [4];
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    bit          accepted;
    int          acceptCyc;
    int          pulses = 0;
    logic [31:0] obsR;
    logic        obsErr;

    function automatic bit reqErr(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // One clock cycle: check this cycle's outputs against the model, then advance.
    task automatic cycle();
        bit    expDone, expAok, e;
        pend_t p;
        int    idx, nb, lane;
        logic [31:0] w;
        expDone = (q.size() > 0) && (q[0].due == cyc);
        expAok  = (q.size() == 0) || expDone;
        nCmp++;
        assert (dOkA[sel] === expDone) else begin
            nFail++; $error("FAIL data_ok sel=%0d cyc=%0d got=%b exp=%b", sel, cyc, dOkA[sel], expDone);
        end
        if (expDone) begin
            p = q.pop_front();
            obsR = rdA[sel]; obsErr = errA[sel]; pulses++;
            if (p.known) begin
                nCmp++;
                assert (rdA[sel] === p.rdata) else begin
                    nFail++; $error("FAIL rdata sel=%0d cyc=%0d got=%h exp=%h", sel, cyc, rdA[sel], p.rdata);
                end
            end
            nCmp++;
            assert (errA[sel] === p.err) else begin
                nFail++; $error("FAIL err sel=%0d cyc=%0d got=%b exp=%b", sel, cyc, errA[sel], p.err);
            end
            lastR[sel] = p.rdata; lastKnown[sel] = p.known;
        end else begin
            if (lastKnown[sel]) begin
                nCmp++;
                assert (rdA[sel] === lastR[sel]) else begin
                    nFail++; $error("FAIL rdata_hold sel=%0d cyc=%0d got=%h exp=%h", sel, cyc, rdA[sel], lastR[sel]);
                end
            end
            nCmp++;
            assert (errA[sel] === 1'b0) else begin
                nFail++; $error("FAIL err_idle sel=%0d cyc=%0d got=%b exp=0", sel, cyc, errA[sel]);
            end
        end
        nCmp++;
        assert (aokA[sel] === expAok) else begin
            nFail++; $error("FAIL addr_ok sel=%0d cyc=%0d got=%b exp=%b", sel, cyc, aokA[sel], expAok);
        end
        accepted = 1'b0;
        if (reqV && expAok) begin
            idx = int'(addrV[11:2]);
            e   = reqErr(sizeV, addrV);
            p.due = cyc + sel + 1; p.rdata = mdl[sel][idx]; p.known = known[sel][idx]; p.err = e;
            q.push_back(p);
            if (wrV && !e) begin
                w  = mdl[sel][idx];
                nb = 1 << sizeV;
                for (int k = 0; k < nb; k++) begin
                    lane = int'(addrV[1:0]) + k;
                    w[8*lane +: 8] = wdataV[8*lane +: 8];
                end
                mdl[sel][idx] = w;
                if (nb == 4) known[sel][idx] = 1'b1;
            end
            $display("txn sel=%0d cyc=%0d %s size=%0d addr=%h wdata=%h err=%0d", sel, cyc,
                     wrV ? "WR" : "RD", sizeV, addrV, wdataV, e);
            accepted  = 1'b1;
            acceptCyc = cyc;
        end
        @(posedge clk); #1; cyc++;
    endtask

    // Present a request and hold it until accepted (req stays high afterward).
    task automatic issue(input bit w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        reqV = 1'b1; wrV = w; sizeV = s; addrV = a; wdataV = d;
        accepted = 1'b0;
        while (!accepted && n < 40) begin cycle(); n++; end
        nCmp++;
        assert (accepted) else begin
            nFail++; $error("FAIL accept_timeout sel=%0d addr=%h got=0 exp=1", sel, a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        reqV = 1'b0;
        while (q.size() > 0 && n < 40) begin cycle(); n++; end
        nCmp++;
        assert (q.size() == 0) else begin
            nFail++; $error("FAIL drain_timeout sel=%0d got=%0d exp=0", sel, q.size());
            q.delete();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nFail++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int c1, p0;
        logic [31:0] a;
        for (int s = 0; s < 4; s++) begin lastR[s] = 32'd0; lastKnown[s] = 1'b1; end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk("reset_addr_ok", 32'(aokA[s]), 32'd1);
            chk("reset_data_ok", 32'(dOkA[s]), 32'd0);
            chk("reset_rdata", rdA[s], 32'd0);
            chk("reset_err", 32'(errA[s]), 32'd0);
        end
        rst = 1'b0;

        // Word write then word read, LATENCY=2.
        sel = 1;
        issue(1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF); drain();
        issue(1'b0, 2'd2, 32'h0000_1000, 32'h0);          drain();
        chk("t1_rdata", obsR, 32'hDEAD_BEEF);
        chk("t1_err", 32'(obsErr), 32'd0);

        // Byte write into a known word.
        issue(1'b1, 2'd2, 32'h0000_1000, 32'h1122_3344); drain();
        issue(1'b1, 2'd0, 32'h0000_1002, 32'h00AA_0000); drain();
        chk("t2_byte_err", 32'(obsErr), 32'd0);
        issue(1'b0, 2'd2, 32'h0000_1000, 32'h0);          drain();
        chk("t2_rdata", obsR, 32'h11AA_3344);

        // Misaligned halfword write: error, no array change.
        issue(1'b1, 2'd1, 32'h0000_1001, 32'hFFFF_FFFF); drain();
        chk("t3_err", 32'(obsErr), 32'd1);
        issue(1'b0, 2'd2, 32'h0000_1000, 32'h0);          drain();
        chk("t3_rdata", obsR, 32'h11AA_3344);
        chk("t3_err_read", 32'(obsErr), 32'd0);

        // Continuous req, LATENCY=1: four writes and four reads back-to-back.
        sel = 0;
        p0 = pulses;
        issue(1'b1, 2'd2, 32'h0000_0200, 32'hA0A0_0001);
        c1 = acceptCyc;
        for (int i = 1; i < 4; i++) issue(1'b1, 2'd2, 32'h0000_0200 + 32'(4 * i), 32'hA0A0_0001 + 32'(i));
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'h0000_0200 + 32'(4 * i), 32'h0);
        chk("t4_accept_span", 32'(acceptCyc - c1), 32'd7);
        drain();
        chk("t4_rdata_last", obsR, 32'hA0A0_0004);
        chk("t4_pulses", 32'(pulses - p0), 32'd8);

        // Reset in the cycle after a read accept, LATENCY=3.
        sel = 2;
        issue(1'b1, 2'd2, 32'h0000_0040, 32'h5555_AAAA); drain();
        issue(1'b0, 2'd2, 32'h0000_0040, 32'h0);
        reqV = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_data_ok", 32'(dOkA[sel]), 32'd0);
        chk("t5_rst_addr_ok", 32'(aokA[sel]), 32'd1);
        chk("t5_rst_rdata", rdA[sel], 32'd0);
        @(posedge clk); #1; cyc++;
        rst = 1'b0;
        q.delete();
        for (int s = 0; s < 4; s++) begin lastR[s] = 32'd0; lastKnown[s] = 1'b1; end
        repeat (5) cycle();
        issue(1'b0, 2'd2, 32'h0000_0040, 32'h0); drain();
        chk("t5_mem_kept", obsR, 32'h5555_AAAA);

        // Second request raised while busy, LATENCY=4.
        sel = 3;
        issue(1'b1, 2'd2, 32'h0000_0080, 32'h0BAD_F00D); drain();
        issue(1'b0, 2'd2, 32'h0000_0080, 32'h0);
        c1 = acceptCyc;
        issue(1'b0, 2'd2, 32'h0000_0080, 32'h0);
        chk("t6_accept_gap", 32'(acceptCyc - c1), 32'd4);
        drain();
        chk("t6_rdata", obsR, 32'h0BAD_F00D);

        // Randomized mix on LATENCY 1 and 2, with aliased upper address bits.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'h0000_0300 + 32'(4 * i), $urandom);
            drain();
            for (int i = 0; i < 60; i++) begin
                a = ($urandom & 32'hFFFF_F000) | 32'h0000_0300 |
                    (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
                if ($urandom_range(0, 2) == 0) begin reqV = 1'b0; cycle(); end
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
